// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared op/state types and constants for the multiply/divide sequencer
package muldiv_ctrl_pkg;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t S_IDLE = 2'd0;
  localparam muldiv_state_t S_MUL  = 2'd1;
  localparam muldiv_state_t S_DIV  = 2'd2;
  localparam muldiv_state_t S_DONE = 2'd3;
  localparam int DIV_CYCLES = 32;
endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: unsigned 32-bit restoring divider, one quotient bit per step
module div_iter import muldiv_ctrl_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotNext,
  output logic [31:0] remNext,
  output logic        done
);
  logic [31:0] rem, quot, dvs;
  logic [5:0]  count;
  logic [32:0] trial;
  logic        qBit;
  // quot starts as the dividend and shifts quotient bits in from the right
  assign trial    = {rem, quot[31]} - {1'b0, dvs};
  assign qBit     = ~trial[32];
  assign remNext  = qBit ? trial[31:0] : {rem[30:0], quot[31]};
  assign quotNext = {quot[30:0], qBit};
  assign done     = count == 6'(DIV_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      rem   <= '0;
      quot  <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (load) begin
      rem   <= '0;
      quot  <= dividend;
      dvs   <= divisor;
      count <= '0;
    end else if (step) begin
      rem   <= remNext;
      quot  <= quotNext;
      count <= count + 6'd1;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer driving HI/LO write pulses
module muldiv_ctrl import muldiv_ctrl_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        hi_we,
  output logic        lo_we
);
  muldiv_state_t state, nextState;
  muldiv_op_t  opReg;
  logic [31:0] aReg, bReg, magA, magB, quotNext, remNext, qFix, rFix;
  logic [63:0] prod;
  logic        accept, isDiv, divDone, mulSigned, divSigned;
  assign isDiv  = op == MD_DIV || op == MD_DIVU;
  assign accept = state == S_IDLE && start && !flush;
  assign stall  = state == S_MUL || state == S_DIV || accept;
  assign busy   = state != S_IDLE;
  assign magA   = op == MD_DIV && src_a[31] ? -src_a : src_a;
  assign magB   = op == MD_DIV && src_b[31] ? -src_b : src_b;
  assign mulSigned = opReg == MD_MULT;
  assign divSigned = opReg == MD_DIV;
  // low 64 bits of the sign-extended product equal the signed 32x32 product
  assign prod = {{32{mulSigned & aReg[31]}}, aReg} * {{32{mulSigned & bReg[31]}}, bReg};
  assign qFix = divSigned && (aReg[31] ^ bReg[31]) ? -quotNext : quotNext;
  assign rFix = divSigned && aReg[31] ? -remNext : remNext;
  always_comb
    nextState = flush ? S_IDLE :
                state == S_IDLE ? (start ? (isDiv ? S_DIV : S_MUL) : S_IDLE) :
                state == S_MUL  ? S_DONE :
                state == S_DIV  ? (divDone ? S_DONE : S_DIV) : S_IDLE;
  div_iter u_div (
    .clk(clk), .reset(reset), .load(accept && isDiv), .step(state == S_DIV && !flush),
    .dividend(magA), .divisor(magB), .quotNext(quotNext), .remNext(remNext), .done(divDone)
  );
  // results land in the output registers on the edge entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      opReg  <= MD_MULT;
      aReg   <= '0;
      bReg   <= '0;
      hi_out <= '0;
      lo_out <= '0;
      hi_we  <= 1'b0;
      lo_we  <= 1'b0;
    end else begin
      state <= nextState;
      hi_we <= nextState == S_DONE;
      lo_we <= nextState == S_DONE;
      if (accept) begin
        opReg <= op;
        aReg  <= src_a;
        bReg  <= src_b;
      end
      if (nextState == S_DONE) {hi_out, lo_out} <= state == S_MUL ? prod : {rFix, qFix};
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized + directed scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;
  logic clk = 0, reset = 1, start = 0, flush = 0;
  muldiv_op_t op = MD_MULT;
  logic [31:0] src_a = 0, src_b = 0, hi_out, lo_out;
  logic stall, busy, hi_we, lo_we;
  int checks = 0, errors = 0;
  logic [63:0] expq[$];

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .busy(busy), .hi_out(hi_out), .lo_out(lo_out),
    .hi_we(hi_we), .lo_we(lo_we)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
    longint p;
    logic [31:0] ma, mb, q, r;
    bit sgn;
    if (o == MD_MULTU) return {32'b0, a} * {32'b0, b};
    if (o == MD_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    sgn = o == MD_DIV;
    ma = sgn && a[31] ? -a : a;
    mb = sgn && b[31] ? -b : b;
    q = mb == 0 ? 32'hFFFF_FFFF : ma / mb;
    r = mb == 0 ? ma : ma % mb;
    if (sgn && (a[31] != b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk)
    if (!reset && (hi_we || lo_we)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we hi_we=%b lo_we=%b with no pending op", hi_we, lo_we);
      end else begin
        logic [63:0] e;
        e = expq.pop_front();
        if ({hi_out, lo_out} !== e || !(hi_we && lo_we)) begin
          errors++;
          $display("FAIL result got hi=%h lo=%h we=%b%b want hi=%h lo=%h we=11",
                   hi_out, lo_out, hi_we, lo_we, e[63:32], e[31:0]);
        end
      end
    end

  // issue one op at posedge+1 in IDLE; returns at posedge+1 after its DONE cycle
  task automatic run_op(muldiv_op_t o, logic [31:0] a, logic [31:0] b, bit hold);
    int n;
    bit dv;
    dv = o == MD_DIV || o == MD_DIVU;
    start = 1; op = o; src_a = a; src_b = b;
    expq.push_back(model(o, a, b));
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      if (n > 1) begin src_a = $urandom; src_b = $urandom; end
      @(negedge clk);
    end
    chk(dv ? "div_stall_cycles" : "mul_stall_cycles", 64'(n), dv ? 64'd33 : 64'd2);
    @(posedge clk); #1;
    if (!hold) start = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_busy", {stall, busy}, 0);
    chk("rst_we", {hi_we, lo_we}, 0);
    chk("rst_hilo", {hi_out, lo_out}, 0);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(MD_DIV, -32'd7, 32'd2, 0);
    run_op(MD_DIVU, 32'd100, 32'd0, 0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_DIV, -32'd9, 32'd0, 0);
    // flush during divide iteration 10
    start = 1; op = MD_DIVU; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1 flush = 1; start = 0;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_idle", {stall, busy}, 0);
    @(posedge clk); #1;
    run_op(MD_MULTU, 32'd6, 32'd7, 0);
    // reset while in MUL
    start = 1; op = MD_MULT; src_a = 32'd5; src_b = 32'd9;
    @(posedge clk); #1 reset = 1; start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_stall_busy", {stall, busy}, 0);
    chk("midrst_we", {hi_we, lo_we}, 0);
    chk("midrst_hilo", {hi_out, lo_out}, 0);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;
    // back-to-back with start held through DONE
    run_op(MD_DIVU, 32'd12345, 32'd17, 1);
    run_op(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (25) begin
      muldiv_op_t o;
      logic [31:0] a, b;
      o = muldiv_op_t'($urandom_range(0, 3));
      a = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(o, a, b, $urandom_range(0, 1) == 1);
    end
    start = 0;
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
